ex_muldiv: RTL
==============

# ex_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage directly downstream of the ID/EX pipeline register. It decodes the instruction held in ID/EX. It executes MULT/MULTU/DIV/DIVU over multiple cycles and performs MTHI/MTLO/MFHI/MFLO. While an operation is in flight it raises `stall`, which freezes PC, IF/ID and ID/EX.

## Interface
Parameters:
- none; operand width fixed at 32, iteration count fixed at 32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `inst`  in  32  instruction from ID/EX `inst_o`.
- `rs_data`  in  32  ID/EX `ReadData1_o`; dividend, multiplicand, MT source.
- `rt_data`  in  32  ID/EX `ReadData2_o`; divisor, multiplier.
- `flush`  in  1  kill the EX instruction; aborts any in-flight operation.
- `stall`  out  1  hold upstream stages this cycle.
- `busy`  out  1  FSM not IDLE.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.
- `mf_data`  out  32  HI for MFHI, LO for MFLO, else 0; combinational.
- `mf_valid`  out  1  EX instruction is MFHI or MFLO.

## Operation
- Decode: `inst[31:26]==0` and funct `inst[5:0]`:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - Any other instruction is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On a mul/div op with `flush`=0: latch the operands and the op, clear the 5-bit counter, go to BUSY. `stall`=1 combinationally in this cycle.
  - MTHI/MTLO: write `rs_data` to HI/LO at the edge; no stall.
- BUSY:
  - `stall`=1.
  - One iteration per cycle, counter 0..31.
  - At the edge with counter==31: write HI/LO, go to DONE.
- DONE:
  - `stall`=0, so the instruction leaves EX at this edge.
  - Return to IDLE unconditionally. The still-present mul/div inst is not re-issued.
- Multiply:
  - Shift-add over the 64-bit product; {HI,LO}=product.
  - Signed ops convert operands to magnitudes, then negate the 64-bit result if the signs differ.
- Divide:
  - Restoring division; LO=quotient, HI=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: LO=0xFFFFFFFF, HI=`rs_data` (DIV and DIVU).
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide edge cases are detected at issue but still take the full latency.
- `flush`:
  - In BUSY or DONE: go to IDLE, HI/LO unchanged, `stall`=0 that cycle.
  - In IDLE: suppresses issue and any MT write.
- MFHI/MFLO read the current registers. No bypass is needed, because a preceding mul/div has completed before any later instruction reaches EX.

## Timing
- Reset values: state=IDLE, HI=LO=0, counter=0, `stall`=0, `busy`=0, `mf_data`=0, `mf_valid`=0.
- Reset mid-operation: immediate return to IDLE; the partial result is discarded and HI/LO read 0.
- Iterative mul/div: `stall` high for 33 consecutive cycles (issue cycle + 32 BUSY). HI/LO are visible from the first DONE cycle. Total EX occupancy is 34 cycles.
- Back-to-back mul/div: the second issues in the IDLE cycle after DONE.
- MTHI/MTLO: the result is visible on `hi_o`/`lo_o` the cycle after the edge.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle 32x32 product computed in the issue cycle and go IDLE->DONE directly.
  - `stall` is high for 1 cycle; HI/LO are written at the issue edge.
  - DIV/DIVU are unchanged.
- Undefined: all four ops are iterative as described above.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=3 -> 33 stall cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x2, LO=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=100, rt=7 -> LO=14, HI=2.
- DIV rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; no X on any output.
- MTHI rs=0x1234 then MFHI -> no stall, `hi_o`=0x1234 next cycle, `mf_data`=0x1234 with `mf_valid`=1 during MFHI.
- MULT issued, `flush` at BUSY count 10 -> `stall` drops that cycle, HI/LO keep prior values; `reset` asserted mid-DIV -> all outputs 0, IDLE.
- With `MULDIV_FAST_MULT_EN`: MULT 6*7 -> `stall` for exactly 1 cycle, LO=42, HI=0; DIV latency remains 33 stall cycles.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU with HI/LO and MT/MF moves.
// Optional MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU, DONE after issue.
module ex_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data,
  output logic        mf_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  state_t      state;
  logic [4:0]  cnt;
  logic        op_div;
  logic        neg_q;
  logic        neg_r;
  logic        spec;
  logic [63:0] spec_res;
  logic [63:0] acc;
  logic [63:0] x;
  logic [31:0] y;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [5:0]  funct;
  logic        is_r;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic        is_mul, is_div, sgn;
  logic        issue;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  logic [63:0] prod_n, mul_res;
  logic [32:0] r_sh, r_n;
  logic        ge;
  logic [31:0] q_n, q_f, r_f;
  logic [63:0] fin_res;

  logic        unused_ok;
  assign unused_ok = ^inst[25:6];

  // decode the instruction held in ID/EX
  always_comb begin
    funct   = inst[5:0];
    is_r    = (inst[31:26] == 6'd0);
    is_mfhi = is_r && (funct == F_MFHI);
    is_mflo = is_r && (funct == F_MFLO);
    is_mthi = is_r && (funct == F_MTHI);
    is_mtlo = is_r && (funct == F_MTLO);
    is_mul  = is_r && (funct == F_MULT || funct == F_MULTU);
    is_div  = is_r && (funct == F_DIV || funct == F_DIVU);
    sgn     = ~funct[0];
    issue   = (state == IDLE) && (is_mul || is_div) && !flush;
    a_neg   = sgn && rs_data[31];
    b_neg   = sgn && rt_data[31];
    a_mag   = a_neg ? (32'd0 - rs_data) : rs_data;
    b_mag   = b_neg ? (32'd0 - rt_data) : rt_data;
  end

  // one shift-add / restoring-divide step plus final sign fixup
  always_comb begin
    prod_n  = y[0] ? (acc + x) : acc;
    mul_res = neg_q ? (64'd0 - prod_n) : prod_n;
    r_sh    = {acc[31:0], y[31]};
    ge      = (r_sh >= {1'b0, x[31:0]});
    r_n     = ge ? (r_sh - {1'b0, x[31:0]}) : r_sh;
    q_n     = {y[30:0], ge};
    q_f     = neg_q ? (32'd0 - q_n) : q_n;
    r_f     = neg_r ? (32'd0 - r_n[31:0]) : r_n[31:0];
    if (!op_div)
      fin_res = mul_res;
    else if (spec)
      fin_res = spec_res;
    else
      fin_res = {r_f, q_f};
  end

  // stall covers the issue cycle and every BUSY cycle unless flushed
  always_comb begin
    stall    = issue || ((state == BUSY) && !flush);
    busy     = (state != IDLE);
    hi_o     = hi;
    lo_o     = lo;
    mf_valid = is_mfhi || is_mflo;
    mf_data  = is_mfhi ? hi : (is_mflo ? lo : 32'd0);
  end

  // FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec     <= 1'b0;
      spec_res <= 64'd0;
      acc      <= 64'd0;
      x        <= 64'd0;
      y        <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!flush) begin
            if (is_mthi) hi <= rs_data;
            if (is_mtlo) lo <= rs_data;
          end
          if (issue) begin
            cnt    <= 5'd0;
            op_div <= is_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc    <= 64'd0;
            x      <= is_div ? {32'd0, b_mag} : {32'd0, a_mag};
            y      <= is_div ? a_mag : b_mag;
            spec   <= 1'b0;
            if (is_div && rt_data == 32'd0) begin
              spec     <= 1'b1;
              spec_res <= {rs_data, 32'hFFFF_FFFF};
            end else if (is_div && sgn &&
                         rs_data == 32'h8000_0000 &&
                         rt_data == 32'hFFFF_FFFF) begin
              spec     <= 1'b1;
              spec_res <= {32'd0, 32'h8000_0000};
            end
            state <= BUSY;
`ifdef MULDIV_FAST_MULT_EN
            if (is_mul) begin
              {hi, lo} <= $signed({{32{a_neg}}, rs_data}) *
                          $signed({{32{b_neg}}, rt_data});
              state    <= DONE;
            end
`endif
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (op_div) begin
              acc <= {31'd0, r_n};
              y   <= q_n;
            end else begin
              acc <= prod_n;
              x   <= x << 1;
              y   <= y >> 1;
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              {hi, lo} <= fin_res;
              state    <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
